// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester side and the UART side of the transmit arbiter.
//   req_i      requester levels, one bit per source
//   data_i     packed bytes, source k on [8k+7:8k]
//   tx_rdy_i   UART transmitter idle flag (1 = idle)
//   tx_start_o one-cycle start pulse to the UART
//   tx_data_o  latched byte for the UART
//   gnt_o      one-hot grant held for the whole transaction
//   done_o     one-cycle completion pulse on the granted bit
//   busy_o     arbiter not idle
//   err_o      one-cycle handshake timeout pulse
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
   logic [N_REQ-1:0]   req_i;
   logic [8*N_REQ-1:0] data_i;
   logic               tx_rdy_i;
   logic               tx_start_o;
   logic [7:0]         tx_data_o;
   logic [N_REQ-1:0]   gnt_o;
   logic [N_REQ-1:0]   done_o;
   logic               busy_o;
   logic               err_o;
   modport slave (
      input  req_i, data_i, tx_rdy_i,
      output tx_start_o, tx_data_o, gnt_o, done_o, busy_o, err_o
   );
   modport master (
      output req_i, data_i, tx_rdy_i,
      input  tx_start_o, tx_data_o, gnt_o, done_o, busy_o, err_o
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte sources.
//   clk_i  system clock
//   rst_i  asynchronous active-low reset
//   bus    uart_tx_arbiter_if.slave: requests/bytes/tx_rdy in, start/data/grant/done/busy/err out
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   uart_tx_arbiter_if.slave  bus
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;
   state_t           state, state_n;
   logic [PW-1:0]    ptr, ptr_n, sel, idx;
   logic [TW-1:0]    timer, timer_n;
   logic             grant, ack_to, fin;
   logic             tx_start_n, busy_n, err_n;
   logic [7:0]       tx_data_n;
   logic [N_REQ-1:0] gnt_n, done_n;
   // The pulse cycle of done_o/err_o blocks a new grant, so completion and grant never coincide.
   assign grant  = (state == IDLE) && bus.tx_rdy_i && (|bus.req_i) && !(|bus.done_o) && !bus.err_o;
   assign ack_to = (state == WAIT_ACK) && bus.tx_rdy_i && (timer == TW'(TIMEOUT_CYC - 1));
   assign fin    = (state == WAIT_DONE) && bus.tx_rdy_i;
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state          <= IDLE;
         ptr            <= PW'(N_REQ - 1);
         timer          <= '0;
         bus.tx_start_o <= 1'b0;
         bus.tx_data_o  <= '0;
         bus.gnt_o      <= '0;
         bus.done_o     <= '0;
         bus.busy_o     <= 1'b0;
         bus.err_o      <= 1'b0;
      end else begin
         state          <= state_n;
         ptr            <= ptr_n;
         timer          <= timer_n;
         bus.tx_start_o <= tx_start_n;
         bus.tx_data_o  <= tx_data_n;
         bus.gnt_o      <= gnt_n;
         bus.done_o     <= done_n;
         bus.busy_o     <= busy_n;
         bus.err_o      <= err_n;
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      state_n = grant ? START : IDLE;
         START:     state_n = WAIT_ACK;
         WAIT_ACK:  state_n = !bus.tx_rdy_i ? WAIT_DONE : ack_to ? IDLE : WAIT_ACK;
         WAIT_DONE: state_n = fin ? IDLE : WAIT_DONE;
         default:   state_n = IDLE;
      endcase
   end
   always_comb begin
      // Scan from the farthest offset down so the nearest requester after ptr wins.
      sel = ptr;
      idx = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = PW'((int'(ptr) + i) % N_REQ);
         if (bus.req_i[idx]) sel = idx;
      end
      tx_start_n = grant;
      tx_data_n  = grant ? bus.data_i[{sel, 3'b000} +: 8] : bus.tx_data_o;
      gnt_n      = grant ? N_REQ'(1) << sel : (ack_to || fin) ? '0 : bus.gnt_o;
      done_n     = fin ? bus.gnt_o : '0;
      err_n      = ack_to;
      busy_n     = state_n != IDLE;
      ptr_n      = grant ? sel : ptr;
      // Saturating timer: it never wraps back into the timeout window.
      timer_n    = (state == START) ? '0 :
                   (state == WAIT_ACK && bus.tx_rdy_i && timer != '1) ? timer + 1'b1 : timer;
   end
endmodule
